// File: rtl/priority_arb_pipe_pkg.sv
// Shared definitions for the priority arbiter pipeline stage:
// FSM state encoding and default configuration constants.
package priority_arb_pipe_pkg;

    // Default request vector width and grant counter width
    localparam int DEF_N  = 8;
    localparam int DEF_CW = 16;

    // IDLE: no grant held; HOLD: a grant is held and presented downstream
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

endpackage : priority_arb_pipe_pkg

// File: rtl/priority_arb_pipe_prio_select.sv
// Combinational winner selection. The search begins at i_start and walks
// downward with wraparound (i_start, i_start-1, ..., 0, N-1, ...); the first
// set request bit wins. With i_start = N-1 this is plain highest-bit priority.
module prio_select #(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] i_req,
    input  logic [W-1:0] i_start,
    output logic [W-1:0] o_idx,
    output logic [N-1:0] o_onehot,
    output logic         o_any
);

    int           w_pos_int;
    logic [W-1:0] w_pos;

    // Walk the request vector from the start position downward and keep the first hit
    always_comb begin
        o_idx     = '0;
        o_any     = 1'b0;
        w_pos_int = 0;
        w_pos     = '0;
        for (int i = 0; i < N; i++) begin
            w_pos_int = int'(i_start) - i;
            if (w_pos_int < 0) begin
                w_pos_int = w_pos_int + N;
            end else begin
                w_pos_int = w_pos_int;
            end
            w_pos = W'(w_pos_int);
            if (!o_any && i_req[w_pos]) begin
                o_any = 1'b1;
                o_idx = w_pos;
            end else begin
                o_any = o_any;
            end
        end
    end

    // One-hot form of the winner; all zeros when nothing is requested
    always_comb begin
        o_onehot = '0;
        if (o_any) begin
            o_onehot[o_idx] = 1'b1;
        end else begin
            o_onehot = '0;
        end
    end

endmodule : prio_select

// File: rtl/priority_arb_pipe.sv
// Single-entry arbitration stage: accepts a request vector with valid/ready,
// registers the winning index (one cycle latency) and holds it until the
// consumer takes it. Back-to-back grants are possible without a bubble.
// An accepted all-zero request produces a one-cycle zero_err pulse.
// Optional feature: define PRIORITY_ARB_ROUND_ROBIN_EN to rotate the search
// start below the last granted index; otherwise strict highest-bit priority.
module priority_arb_pipe
    import priority_arb_pipe_pkg::*;
#(
    parameter int N  = DEF_N,
    parameter int CW = DEF_CW
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N-1:0]          req,
    input  logic                  req_valid,
    output logic                  req_ready,
    output logic [$clog2(N)-1:0]  grant_idx,
    output logic [N-1:0]          grant_onehot,
    output logic                  grant_valid,
    input  logic                  grant_ready,
    output logic                  zero_err,
    output logic [CW-1:0]         grant_cnt
);

    localparam int W = $clog2(N);

    state_t       r_state;
    logic         r_gv;
    logic [W-1:0] r_idx;
    logic [N-1:0] r_oh;
    logic         r_zero;
    logic [CW-1:0] r_cnt;

    logic         w_in_xfer;
    logic         w_out_xfer;
    logic         w_load;
    logic         w_zero;
    logic [W-1:0] w_start;
    logic [W-1:0] w_sel_idx;
    logic [N-1:0] w_sel_oh;
    logic         w_sel_any;

    // In HOLD the stage can only take a new request when the held one leaves
    assign req_ready  = (r_state == ST_IDLE) ? 1'b1 : grant_ready;
    assign w_in_xfer  = req_valid & req_ready;
    assign w_out_xfer = r_gv & grant_ready;
    assign w_load     = w_in_xfer & w_sel_any;
    assign w_zero     = w_in_xfer & ~w_sel_any;

`ifdef PRIORITY_ARB_ROUND_ROBIN_EN
    logic [W-1:0] r_ptr;
    logic [W-1:0] w_ptr_next;

    // A grant leaving this cycle moves the search start just below it, and a
    // simultaneous new request already sees the moved start.
    assign w_ptr_next = (r_idx == '0) ? W'(N - 1) : (r_idx - W'(1));
    assign w_start    = w_out_xfer ? w_ptr_next : r_ptr;

    // Round-robin pointer follows each completed output transfer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= W'(N - 1);
        end else if (w_out_xfer) begin
            r_ptr <= w_ptr_next;
        end else begin
            r_ptr <= r_ptr;
        end
    end
`else
    assign w_start = W'(N - 1);
`endif

    prio_select #(
        .N (N),
        .W (W)
    ) u_sel (
        .i_req    (req),
        .i_start  (w_start),
        .o_idx    (w_sel_idx),
        .o_onehot (w_sel_oh),
        .o_any    (w_sel_any)
    );

    // Grant-holding FSM with registered grant, error pulse and counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_gv    <= 1'b0;
            r_idx   <= '0;
            r_oh    <= '0;
            r_zero  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_zero <= w_zero;
            if (w_out_xfer && (r_cnt != '1)) begin
                r_cnt <= r_cnt + CW'(1);
            end else begin
                r_cnt <= r_cnt;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_load) begin
                        r_state <= ST_HOLD;
                        r_gv    <= 1'b1;
                        r_idx   <= w_sel_idx;
                        r_oh    <= w_sel_oh;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_HOLD: begin
                    if (w_out_xfer && w_load) begin
                        r_idx <= w_sel_idx;
                        r_oh  <= w_sel_oh;
                    end else if (w_out_xfer) begin
                        r_state <= ST_IDLE;
                        r_gv    <= 1'b0;
                        r_idx   <= '0;
                        r_oh    <= '0;
                    end else begin
                        r_state <= ST_HOLD;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_gv    <= 1'b0;
                    r_idx   <= '0;
                    r_oh    <= '0;
                end
            endcase
        end
    end

    assign grant_valid  = r_gv;
    assign grant_idx    = r_idx;
    assign grant_onehot = r_oh;
    assign zero_err     = r_zero;
    assign grant_cnt    = r_cnt;

endmodule : priority_arb_pipe

// File: tb/tb_priority_arb_pipe.sv
// Self-checking bench for priority_arb_pipe (N=8). A second instance with
// CW=2 shares all inputs to observe counter saturation.
module tb_priority_arb_pipe;

    logic        clk;
    logic        rst;
    logic [7:0]  req;
    logic        req_valid;
    logic        grant_ready;
    logic        req_ready, req_ready2;
    logic [2:0]  grant_idx, grant_idx2;
    logic [7:0]  grant_onehot, grant_onehot2;
    logic        grant_valid, grant_valid2;
    logic        zero_err, zero_err2;
    logic [15:0] grant_cnt;
    logic [1:0]  grant_cnt2;

    int errors = 0;
    int checks = 0;

    // reference model state
    bit m_valid;
    int m_idx;
    int m_cnt;
    int m_ptr;
    bit m_zero;
    bit exp_ready_seen;
    logic seen_ready;

    priority_arb_pipe #(.N(8), .CW(16)) dut (
        .clk(clk), .rst(rst), .req(req), .req_valid(req_valid), .req_ready(req_ready),
        .grant_idx(grant_idx), .grant_onehot(grant_onehot), .grant_valid(grant_valid),
        .grant_ready(grant_ready), .zero_err(zero_err), .grant_cnt(grant_cnt)
    );

    priority_arb_pipe #(.N(8), .CW(2)) dut2 (
        .clk(clk), .rst(rst), .req(req), .req_valid(req_valid), .req_ready(req_ready2),
        .grant_idx(grant_idx2), .grant_onehot(grant_onehot2), .grant_valid(grant_valid2),
        .grant_ready(grant_ready), .zero_err(zero_err2), .grant_cnt(grant_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // search downward from start with wrap; first requested position wins
    function automatic int pick(logic [7:0] r, int start);
        for (int k = 0; k < 8; k++) begin
            int p;
            p = (start - k + 8) % 8;
            if (r[p]) return p;
        end
        return 0;
    endfunction

    function automatic logic [7:0] exp_onehot();
        logic [7:0] one;
        one = 8'd1;
        return m_valid ? (one << m_idx) : 8'd0;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_idx = 0; m_cnt = 0; m_ptr = 7; m_zero = 0;
    endtask

    // one clock of behaviour: the held grant leaves first, then a new one may enter
    task automatic model_update(input bit rv, input logic [7:0] rq, input bit gr);
        bit ready, in_x, out_x;
        ready = !m_valid || gr;
        in_x  = rv && ready;
        out_x = m_valid && gr;
        m_zero = in_x && (rq == 8'd0);
        if (out_x) begin
            m_cnt++;
`ifdef PRIORITY_ARB_ROUND_ROBIN_EN
            m_ptr = (m_idx == 0) ? 7 : m_idx - 1;
`endif
            m_valid = 0;
        end
        if (in_x && rq != 8'd0) begin
`ifdef PRIORITY_ARB_ROUND_ROBIN_EN
            m_idx = pick(rq, m_ptr);
`else
            m_idx = pick(rq, 7);
`endif
            m_valid = 1;
        end
    endtask

    // drive one cycle; sample req_ready before the edge, outputs 1ns after it
    task automatic step(input bit rv, input logic [7:0] rq, input bit gr);
        req_valid = rv; req = rq; grant_ready = gr;
        #1;
        seen_ready     = req_ready;
        exp_ready_seen = !m_valid || gr;
        @(posedge clk);
        model_update(rv, rq, gr);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req_valid = 1'b0; req = 8'd0; grant_ready = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 1'b0; req = 8'd0; grant_ready = 1'b0;
        #2;
        checks++; if (grant_valid !== 1'b0) begin errors++; $display("FAIL reset_gv: got %b want 0", grant_valid); end
        checks++; if (grant_idx !== 3'd0) begin errors++; $display("FAIL reset_idx: got %0d want 0", grant_idx); end
        checks++; if (grant_onehot !== 8'd0) begin errors++; $display("FAIL reset_oh: got %h want 00", grant_onehot); end
        checks++; if (zero_err !== 1'b0) begin errors++; $display("FAIL reset_zero: got %b want 0", zero_err); end
        checks++; if (grant_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", grant_cnt); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", req_ready); end
    endtask

    task automatic test_basic();
        step(1'b1, 8'b0000_0101, 1'b0);
        checks++; if (grant_valid !== 1'b1) begin errors++; $display("FAIL basic_gv: got %b want 1", grant_valid); end
        checks++; if (grant_idx !== 3'd2) begin errors++; $display("FAIL basic_idx: got %0d want 2", grant_idx); end
        checks++; if (grant_onehot !== 8'b0000_0100) begin errors++; $display("FAIL basic_oh: got %b want 00000100", grant_onehot); end
        checks++; if (zero_err !== 1'b0) begin errors++; $display("FAIL basic_zero: got %b want 0", zero_err); end
    endtask

    task automatic test_hold();
        for (int c = 0; c < 3; c++) begin
            step(1'b1, 8'h80, 1'b0);
            checks++; if (seen_ready !== 1'b0) begin errors++; $display("FAIL hold_ready c%0d: got %b want 0", c, seen_ready); end
            checks++; if (grant_valid !== 1'b1 || grant_idx !== 3'd2 || grant_onehot !== 8'h04)
                begin errors++; $display("FAIL hold_stable c%0d: got v%b i%0d oh%h want v1 i2 oh04", c, grant_valid, grant_idx, grant_onehot); end
        end
        step(1'b0, 8'h00, 1'b1);
        checks++; if (grant_valid !== 1'b0 || grant_onehot !== 8'h00)
            begin errors++; $display("FAIL hold_release: got v%b oh%h want v0 oh00", grant_valid, grant_onehot); end
        checks++; if (grant_cnt !== 16'd1) begin errors++; $display("FAIL hold_cnt: got %0d want 1", grant_cnt); end
    endtask

    task automatic test_zero();
        step(1'b1, 8'h00, 1'b0);
        checks++; if (zero_err !== 1'b1) begin errors++; $display("FAIL zero_pulse: got %b want 1", zero_err); end
        checks++; if (grant_valid !== 1'b0) begin errors++; $display("FAIL zero_gv: got %b want 0", grant_valid); end
        step(1'b0, 8'h00, 1'b0);
        checks++; if (zero_err !== 1'b0) begin errors++; $display("FAIL zero_clear: got %b want 0", zero_err); end
    endtask

    task automatic test_back_to_back();
        int want;
        do_reset();
        for (int k = 0; k < 6; k++) begin
            step(1'b1, 8'b1000_0001, 1'b1);
`ifdef PRIORITY_ARB_ROUND_ROBIN_EN
            want = (k % 2 == 0) ? 7 : 0;
`else
            want = 7;
`endif
            checks++; if (grant_valid !== 1'b1 || int'(grant_idx) != want)
                begin errors++; $display("FAIL b2b k%0d: got v%b i%0d want v1 i%0d", k, grant_valid, grant_idx, want); end
        end
        checks++; if (grant_cnt !== 16'd5) begin errors++; $display("FAIL b2b_cnt: got %0d want 5", grant_cnt); end
    endtask

    task automatic test_async_reset();
        do_reset();
        step(1'b1, 8'h40, 1'b0);
        step(1'b1, 8'h10, 1'b0);
        checks++; if (grant_valid !== 1'b1 || grant_idx !== 3'd6)
            begin errors++; $display("FAIL areset_pre: got v%b i%0d want v1 i6", grant_valid, grant_idx); end
        rst = 1'b1;
        #1;
        checks++; if (grant_valid !== 1'b0 || grant_idx !== 3'd0 || grant_onehot !== 8'd0 || zero_err !== 1'b0 || grant_cnt !== 16'd0)
            begin errors++; $display("FAIL areset_async: got v%b i%0d oh%h z%b c%0d want all 0", grant_valid, grant_idx, grant_onehot, zero_err, grant_cnt); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL areset_ready: got %b want 1", req_ready); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_saturate();
        do_reset();
        for (int k = 0; k < 6; k++) step(1'b1, 8'h01, 1'b1);
        checks++; if (grant_cnt2 !== 2'd3) begin errors++; $display("FAIL sat_cnt2: got %0d want 3", grant_cnt2); end
        checks++; if (grant_cnt !== 16'd5) begin errors++; $display("FAIL sat_cnt16: got %0d want 5", grant_cnt); end
        for (int k = 0; k < 3; k++) step(1'b1, 8'h01, 1'b1);
        checks++; if (grant_cnt2 !== 2'd3) begin errors++; $display("FAIL sat_hold: got %0d want 3", grant_cnt2); end
    endtask

    task automatic test_random();
        bit rv, gr;
        logic [7:0] rq;
        int exp2;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            rv = ($urandom_range(0, 3) != 0);
            gr = ($urandom_range(0, 2) != 0);
            rq = ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom);
            step(rv, rq, gr);
            exp2 = (m_cnt > 3) ? 3 : m_cnt;
            checks++; if (seen_ready !== exp_ready_seen) begin errors++; $display("FAIL rnd_ready n%0d: got %b want %b", n, seen_ready, exp_ready_seen); end
            checks++; if (grant_valid !== m_valid) begin errors++; $display("FAIL rnd_gv n%0d: got %b want %b", n, grant_valid, m_valid); end
            if (m_valid) begin
                checks++; if (int'(grant_idx) != m_idx) begin errors++; $display("FAIL rnd_idx n%0d: got %0d want %0d", n, grant_idx, m_idx); end
            end
            checks++; if (grant_onehot !== exp_onehot()) begin errors++; $display("FAIL rnd_oh n%0d: got %h want %h", n, grant_onehot, exp_onehot()); end
            checks++; if (zero_err !== m_zero) begin errors++; $display("FAIL rnd_zero n%0d: got %b want %b", n, zero_err, m_zero); end
            checks++; if (int'(grant_cnt) != m_cnt) begin errors++; $display("FAIL rnd_cnt n%0d: got %0d want %0d", n, grant_cnt, m_cnt); end
            checks++; if (int'(grant_cnt2) != exp2) begin errors++; $display("FAIL rnd_cnt2 n%0d: got %0d want %0d", n, grant_cnt2, exp2); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold();
        test_zero();
        test_back_to_back();
        test_async_reset();
        test_saturate();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_priority_arb_pipe

// File: doc/priority_arb_pipe.md
PRIORITY_ARB_PIPE -- requirements
Module: priority_arb_pipe

Interface
REQ-001 SHALL have parameter N, default 8: request vector width, N >= 2.
REQ-002 SHALL have parameter CW, default 16: grant counter width.
REQ-003 SHALL derive localparam W = $clog2(N), the grant index width.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port req, input, N bits: request vector.
REQ-007 SHALL have port req_valid, input, 1 bit: req is presented.
REQ-008 SHALL have port req_ready, output, 1 bit: the block accepts req this cycle.
REQ-009 SHALL have port grant_idx, output, W bits: encoded winner index.
REQ-010 SHALL have port grant_onehot, output, N bits: one-hot winner.
REQ-011 SHALL have port grant_valid, output, 1 bit: grant outputs are valid.
REQ-012 SHALL have port grant_ready, input, 1 bit: the consumer accepts the grant.
REQ-013 SHALL have port zero_err, output, 1 bit: one-cycle pulse when an all-zero req is accepted.
REQ-014 SHALL have port grant_cnt, output, CW bits: saturating count of accepted grants.

Function
REQ-015 SHALL implement a two-state FSM: IDLE (no grant held) and HOLD (grant held, grant_valid=1).
REQ-016 Input transfer = req_valid && req_ready; output transfer = grant_valid && grant_ready.
REQ-017 IDLE: req_ready=1; on a transfer with req!=0, register the winner and go to HOLD; latency is exactly 1 cycle from accept to grant_valid.
REQ-018 IDLE or HOLD: on a transfer with req==0, SHALL not register a grant, SHALL pulse zero_err in the next cycle, and SHALL not change state.
REQ-019 HOLD: req_ready=grant_ready (combinational); grant_idx/grant_onehot SHALL hold stable until the output transfer.
REQ-020 HOLD with an output transfer and a simultaneous input transfer with req!=0 SHALL load the new winner and stay in HOLD (back-to-back, no bubble).
REQ-021 HOLD with an output transfer and no nonzero input transfer SHALL return to IDLE.
REQ-022 Fixed priority: the highest set bit of req wins (bit N-1 highest).
REQ-023 grant_onehot SHALL always equal 1<<grant_idx while grant_valid=1, and SHALL be 0 while grant_valid=0.
REQ-024 grant_cnt SHALL increment on each output transfer and saturate at 2^CW-1 (no wrap).
REQ-025 Changes to req while req_ready=0 SHALL have no effect.

Reset
REQ-026 While rst=1: state=IDLE, grant_valid=0, grant_idx=0, grant_onehot=0, zero_err=0, grant_cnt=0, round-robin pointer=N-1.
REQ-027 Reset asserted mid-HOLD SHALL discard the held grant immediately, without waiting for a clock edge.
REQ-028 req_ready SHALL be 1 in the first cycle after reset deasserts.

Configuration
REQ-029 Macro PRIORITY_ARB_ROUND_ROBIN_EN defined: search starts at pointer ptr and proceeds downward with wrap (ptr, ptr-1, ..., 0, N-1, ...); after each output transfer of index k, ptr=(k==0)?N-1:k-1.
REQ-030 PRIORITY_ARB_ROUND_ROBIN_EN undefined: strict fixed priority per REQ-022 and no pointer register; with the pointer at reset value both modes SHALL pick the same first winner.

Structure
REQ-031 A shared package SHALL hold the FSM state enum (IDLE, HOLD) and the default N and CW constants.
REQ-032 Combinational winner selection SHALL be a sub-module prio_select (inputs req and start pointer; outputs index, one-hot and any).

Verification (N=8)
REQ-033 req=8'b0000_0101 accepted -> next cycle grant_valid=1, grant_idx=2, grant_onehot=8'b0000_0100.
REQ-034 grant held with grant_ready=0 for 3 cycles -> outputs stable, req_ready=0; new req ignored.
REQ-035 req=8'b0000_0000 accepted -> zero_err pulses for 1 cycle, grant_valid stays 0.
REQ-036 grant_ready=1, req_valid=1 every cycle with req=8'b1000_0001 -> fixed priority: idx 7 every cycle; with round-robin: 7,0,7,0.
REQ-037 rst pulsed while in HOLD -> grant_valid=0 asynchronously; all outputs at reset values.
REQ-038 CW=2 with 5 output transfers -> grant_cnt reads 3 and stays at 3.
